// File: rtl/iter_shift_unit.sv
// Bit-serial shifter (SLL/SRL/SRA, plus ROR/ROL when ROTATE_EN is defined); one bit per clock.
// Latency shamt+1 cycles from accept to done; start is ignored unless idle (no queueing).
module iter_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [2:0]         shift_op,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [WIDTH-1:0]   data_in,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done,
  output logic               op_err
);

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROR = 3'b011;
  localparam logic [2:0] OP_ROL = 3'b100;

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t             state, state_nxt;
  logic [2:0]         op_q;
  logic [SHAMT_W-1:0] count;
  logic [WIDTH-1:0]   step_dat;
  logic               op_ok;

  // Reserved (or disabled rotate) ops still burn the count but leave data untouched.
  always_comb begin
    op_ok = 1'b0;
    case (op_q)
      OP_SLL, OP_SRL, OP_SRA: op_ok = 1'b1;
`ifdef ROTATE_EN
      OP_ROR, OP_ROL:         op_ok = 1'b1;
`endif
      default:                op_ok = 1'b0;
    endcase
  end

  always_comb begin
    step_dat = data_out;
    case (op_q)
      OP_SLL: step_dat = {data_out[WIDTH-2:0], 1'b0};
      OP_SRL: step_dat = {1'b0, data_out[WIDTH-1:1]};
      OP_SRA: step_dat = {data_out[WIDTH-1], data_out[WIDTH-1:1]};
`ifdef ROTATE_EN
      OP_ROR: step_dat = {data_out[0], data_out[WIDTH-1:1]};
      OP_ROL: step_dat = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
`endif
      default: step_dat = data_out;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (shamt != '0) ? SHIFT : FINISH;
      SHIFT:   if (count == SHAMT_W'(1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_q     <= OP_SLL;
      count    <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start) begin
            data_out <= data_in;
            count    <= shamt;
            op_q     <= shift_op;
          end
        end
        SHIFT: begin
          data_out <= step_dat;
          count    <= count - SHAMT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign done   = (state == FINISH);
  assign op_err = done & ~op_ok;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed-vector bench for iter_shift_unit; rotate expectations follow ROTATE_EN.
module tb_iter_shift_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  shift_op = 3'b000;
  logic [4:0]  shamt = 5'd0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        busy, done, op_err;

  int n_chk = 0;
  int n_pass = 0;

  iter_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .shift_op(shift_op),
    .shamt(shamt), .data_in(data_in), .data_out(data_out),
    .busy(busy), .done(done), .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Starts one op, watches shamt+6 cycles, optionally re-pulses start (with
  // junk data) at cycle repulse_at, and checks latency, result and done count.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [4:0] sa,
                        input logic [31:0] din, input logic [31:0] exp_dat,
                        input logic exp_err, input int repulse_at);
    int lat = -1;
    int ndone = 0;
    logic [31:0] dat_at_done = 32'hx;
    logic err_at_done = 1'bx;
    @(negedge clk);
    start = 1'b1; shift_op = op; shamt = sa; data_in = din;
    @(negedge clk);
    start = 1'b0; shift_op = 3'b000; shamt = 5'd7; data_in = 32'h5A5A_5A5A;
    chk({tag, "_busy1"}, {31'b0, busy}, 32'd1);
    for (int cyc = 1; cyc <= int'(sa) + 6; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = cyc; dat_at_done = data_out; err_at_done = op_err;
        end
      end
      start = (cyc == repulse_at);
      if (start) data_in = 32'hFFFF_FFFF;
    end
    start = 1'b0;
    chk({tag, "_lat"}, lat, int'(sa) + 1);
    chk({tag, "_dat"}, dat_at_done, exp_dat);
    chk({tag, "_err"}, {31'b0, err_at_done}, {31'b0, exp_err});
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    chk({tag, "_hold"}, data_out, exp_dat);
  endtask

  initial begin
    int ndone;
    #12;
    chk("rst_dat", data_out, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err", {31'b0, op_err}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset mid-shift abandons the op
    @(negedge clk);
    start = 1'b1; shift_op = 3'b000; shamt = 5'd20; data_in = 32'h1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("midrst_dat", data_out, 32'h0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_nodone", ndone, 0);

    run_op("sll4",  3'b000, 5'd4,  32'h0000_0001, 32'h0000_0010, 1'b0, 0);
    run_op("sra31", 3'b010, 5'd31, 32'h8000_00F0, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("srl31", 3'b001, 5'd31, 32'h8000_00F0, 32'h0000_0001, 1'b0, 0);
    run_op("srl0",  3'b001, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 0);
`ifdef ROTATE_EN
    run_op("ror1",  3'b011, 5'd1,  32'h0000_0003, 32'h8000_0001, 1'b0, 0);
    run_op("rol4",  3'b100, 5'd4,  32'hF000_0001, 32'h0000_001F, 1'b0, 0);
`else
    run_op("ror1",  3'b011, 5'd1,  32'h0000_0003, 32'h0000_0003, 1'b1, 0);
    run_op("rol4",  3'b100, 5'd4,  32'hF000_0001, 32'hF000_0001, 1'b1, 0);
`endif
    run_op("rsvd",  3'b111, 5'd3,  32'h0000_1234, 32'h0000_1234, 1'b1, 0);
    run_op("busyst", 3'b000, 5'd8, 32'h0000_0001, 32'h0000_0100, 1'b0, 3);
    run_op("donest", 3'b010, 5'd4, 32'h8000_0000, 32'hF800_0000, 1'b0, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
